// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operands are latched at issue; HI/LO update only on completion, MTHI/MTLO or reset.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_d, lo_d;

    // Result datapath, driven only from the latched operands
    logic signed [63:0] sa64, sb64, prod_s;
    logic [63:0]        prod_u;
    logic               a_neg, b_neg, b_zero;
    logic [31:0]        abs_a, abs_b, abs_b_safe, b_safe;
    logic [31:0]        q_mag, r_mag, div_q, div_r, divu_q, divu_r;

    always_comb begin
        sa64       = $signed({{32{a_q[31]}}, a_q});
        sb64       = $signed({{32{b_q[31]}}, b_q});
        prod_s     = sa64 * sb64;
        prod_u     = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide on magnitudes; the sign fix-up also covers 0x80000000 / -1
        a_neg      = a_q[31];
        b_neg      = b_q[31];
        b_zero     = (b_q == 32'd0);
        abs_a      = a_neg ? 32'(-a_q) : a_q;
        abs_b      = b_neg ? 32'(-b_q) : b_q;
        abs_b_safe = b_zero ? 32'd1 : abs_b;
        b_safe     = b_zero ? 32'd1 : b_q;
        q_mag      = abs_a / abs_b_safe;
        r_mag      = abs_a % abs_b_safe;
        div_q      = (a_neg ^ b_neg) ? 32'(-q_mag) : q_mag;
        div_r      = a_neg ? 32'(-r_mag) : r_mag;
        divu_q     = a_q / b_safe;
        divu_r     = a_q % b_safe;
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = HI;
        lo_d    = LO;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (!b_zero) begin
                                lo_d = div_q;
                                hi_d = div_r;
                            end
                        end
                        OP_DIVU: begin
                            if (!b_zero) begin
                                lo_d = divu_q;
                                hi_d = divu_r;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            HI    <= hi_d;
            LO    <= lo_d;
        end
    end

    assign Busy  = (state == S_BUSY);
    assign Stall = Busy || (Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_MTLO));

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences,
// and randomized ops checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .MDUOp(op), .A(a), .B(b),
        .Busy(busy), .Stall(stall), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference model: full-width arithmetic on 64-bit integers
    task automatic model(input logic [2:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b,
                         inout logic [31:0] m_hi, inout logic [31:0] m_lo, output int m_cycles);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        m_cycles = 0;
        case (m_op)
            3'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; m_cycles = 5; end
            3'd2: begin p = 64'(m_a) * 64'(m_b); {m_hi, m_lo} = p; m_cycles = 5; end
            3'd3: begin
                if (m_b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                m_cycles = 10;
            end
            3'd4: begin
                if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
                m_cycles = 10;
            end
            3'd5: m_hi = m_a;
            3'd6: m_lo = m_a;
            default: ;
        endcase
    endtask

    // Issue one op for one cycle, then count Busy cycles (bounded); HI/LO are final on return
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          output int cycles, output logic stall_start, output logic stall_busy);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        #1 stall_start = stall;
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        cycles = 0;
        stall_busy = 1'b1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            stall_busy &= stall;
        end
    endtask

    logic [31:0] m_hi, m_lo;
    int          cyc, m_cyc;
    logic        s_start, s_busy;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          bcount;

    initial begin
        vecs[0] = '{"mult_neg2x3",   3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{"multu_neg2x3",  3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{"div_m7_2",      3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{"divu_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4] = '{"div_ovf",       3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{"mult_2x3",      3'd1, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 5};

        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_stall", 64'(stall), 64'd0);

        // Directed vectors, also cross-checked against the model
        for (int i = 0; i < 6; i++) begin
            m_hi = hi; m_lo = lo;
            model(vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo, m_cyc);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, s_start, s_busy);
            check({vecs[i].name, "_cycles"}, 64'(cyc), 64'(vecs[i].exp_cycles));
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
            check({vecs[i].name, "_model_hi"}, 64'(hi), 64'(m_hi));
            check({vecs[i].name, "_model_lo"}, 64'(lo), 64'(m_lo));
            check({vecs[i].name, "_stall_start"}, 64'(s_start), 64'd1);
            check({vecs[i].name, "_stall_busy"}, 64'(s_busy), 64'd1);
        end

        // Divide by zero keeps HI/LO
        run_op(3'd5, 32'h11, 32'd0, cyc, s_start, s_busy);
        run_op(3'd6, 32'h22, 32'd0, cyc, s_start, s_busy);
        check("mt_preload_hi", 64'(hi), 64'h11);
        check("mt_preload_lo", 64'(lo), 64'h22);
        run_op(3'd3, 32'd100, 32'd0, cyc, s_start, s_busy);
        check("div0_cycles", 64'(cyc), 64'd10);
        check("div0_hi", 64'(hi), 64'h11);
        check("div0_lo", 64'(lo), 64'h22);
        run_op(3'd4, 32'd100, 32'd0, cyc, s_start, s_busy);
        check("divu0_hi", 64'(hi), 64'h11);
        check("divu0_lo", 64'(lo), 64'h22);

        // MTHI while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h1234;
        #1 check("mthi_busy_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0; a = 32'h0;
        bcount = 1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!busy) break;
            bcount++;
        end
        check("interlock_cycles", 64'(bcount), 64'd5);
        check("interlock_hi", 64'(hi), 64'd0);
        check("interlock_lo", 64'(lo), 64'd6);

        // MTLO in idle: immediate, Busy never rises
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'hABCD;
        #1 check("mtlo_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0;
        bcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy) bcount++;
        end
        check("mtlo_lo", 64'(lo), 64'hABCD);
        check("mtlo_no_busy", 64'(bcount), 64'd0);

        // Reserved op: no stall, no busy, no change
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 32'hDEAD;
        #1 check("op7_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("op7_busy", 64'(busy), 64'd0);
        check("op7_lo", 64'(lo), 64'hABCD);

        // Back-to-back: second MULT in the first cycle after Busy falls
        run_op(3'd1, 32'd7, 32'd9, cyc, s_start, s_busy);
        check("b2b_first_lo", 64'(lo), 64'd63);
        start = 1'b1; op = 3'd2; a = 32'd10; b = 32'd11;
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0;
        bcount = 0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!busy) break;
            bcount++;
        end
        check("b2b_cycles", 64'(bcount), 64'd5);
        check("b2b_lo", 64'(lo), 64'd110);

        // Reset mid-operation: async clear, result discarded
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFE; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; op = 3'd0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_after_busy", 64'(busy), 64'd0);
        check("rst_after_hi", 64'(hi), 64'd0);
        check("rst_after_lo", 64'(lo), 64'd0);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
            m_hi = hi; m_lo = lo;
            model(r_op, r_a, r_b, m_hi, m_lo, m_cyc);
            run_op(r_op, r_a, r_b, cyc, s_start, s_busy);
            check($sformatf("rand%0d_op%0d_cycles", i, r_op), 64'(cyc), 64'(m_cyc));
            check($sformatf("rand%0d_op%0d_hilo", i, r_op), {hi, lo}, {m_hi, m_lo});
            check($sformatf("rand%0d_op%0d_stall", i, r_op), 64'(s_start),
                  64'((r_op >= 3'd1) && (r_op <= 3'd6)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
